// File: rtl/elbeth_pipeline_ctrl_pkg.sv
// Shared types and encodings for the ELBETH pipeline controller.
// The PC select codes are also consumed by the fetch unit.
package elbeth_pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN           = 2'd0,
      ST_TRAP_DRAIN    = 2'd1,
      ST_TRAP_REDIRECT = 2'd2
   } state_e;

   localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_TRAP   = 2'b10;
   localparam logic [1:0] PC_SEL_EPC    = 2'b11;

   typedef struct packed {
      logic       pc_stall;
      logic       ifid_stall;
      logic       idex_stall;
      logic       exmem_stall;
      logic       ifid_flush;
      logic       idex_flush;
      logic       exmem_flush;
      logic [1:0] pc_sel;
      logic       trap_valid;
      logic [3:0] trap_cause;
      logic       trap_timeout;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/elbeth_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of ID.
// Loads to x0 never create a dependency.
module elbeth_hazard_detect (
   input  logic [4:0] i_rs1_addr,
   input  logic [4:0] i_rs2_addr,
   input  logic       i_uses_rs1,
   input  logic       i_uses_rs2,
   input  logic [4:0] i_rd_addr,
   input  logic       i_mem_read,
   output logic       o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   always_comb begin
      w_rs1_hit  = i_uses_rs1 & (i_rs1_addr == i_rd_addr);
      w_rs2_hit  = i_uses_rs2 & (i_rs2_addr == i_rd_addr);
      o_load_use = i_mem_read & (i_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);
   end

endmodule

// File: rtl/elbeth_pipeline_ctrl.sv
// Stall/flush/redirect controller for the 5-stage ELBETH core.
// Sequences precise traps: drain older instructions, then redirect to the trap vector.
module elbeth_pipeline_ctrl
   import elbeth_pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 15,
   parameter int TMO_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       id_except_illegal_instruction,
   input  logic [3:0] id_except_src,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_mem_read,
   input  logic       ex_branch_taken,
   input  logic       ex_xret,
   input  logic       mem_dmem_req,
   input  logic       dmem_ready,
   input  logic       imem_ready,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       idex_stall,
   output logic       exmem_stall,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic [1:0] pc_sel,
   output logic       csr_trap_valid,
   output logic [3:0] csr_trap_cause,
   output logic       trap_timeout
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [3:0]        r_cause;
   logic [3:0]        w_cause_nxt;
   logic [TMO_W-1:0]  r_cnt;
   logic [TMO_W-1:0]  w_cnt_nxt;
   logic              r_tmo;
   logic              w_tmo_nxt;
   logic              w_mem_wait;
   logic              w_load_use;
   ctrl_t             w_ctrl;
   ctrl_t             w_ctrl_out;

   elbeth_hazard_detect u_hazard (
      .i_rs1_addr (id_rs1_addr),
      .i_rs2_addr (id_rs2_addr),
      .i_uses_rs1 (id_uses_rs1),
      .i_uses_rs2 (id_uses_rs2),
      .i_rd_addr  (ex_rd_addr),
      .i_mem_read (ex_mem_read),
      .o_load_use (w_load_use)
   );

   always_comb begin
      w_mem_wait  = mem_dmem_req & ~dmem_ready;
      w_ctrl      = CTRL_IDLE;
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      case (r_state)
         ST_RUN: begin
            if (w_mem_wait) begin
               w_ctrl.pc_stall    = 1'b1;
               w_ctrl.ifid_stall  = 1'b1;
               w_ctrl.idex_stall  = 1'b1;
               w_ctrl.exmem_stall = 1'b1;
            end else if (ex_branch_taken | ex_xret) begin
               // A same-cycle ID exception is on the wrong path and is dropped here.
               w_ctrl.pc_sel     = ex_xret ? PC_SEL_EPC : PC_SEL_BRANCH;
               w_ctrl.ifid_flush = 1'b1;
               w_ctrl.idex_flush = 1'b1;
            end else if (id_except_illegal_instruction) begin
               w_ctrl.pc_stall   = 1'b1;
               w_ctrl.ifid_stall = 1'b1;
               w_ctrl.idex_flush = 1'b1;
               w_cause_nxt       = id_except_src;
               w_cnt_nxt         = '0;
               w_tmo_nxt         = 1'b0;
               w_state_nxt       = ST_TRAP_DRAIN;
            end else if (w_load_use) begin
               w_ctrl.pc_stall   = 1'b1;
               w_ctrl.ifid_stall = 1'b1;
               w_ctrl.idex_flush = 1'b1;
            end else if (!imem_ready) begin
               w_ctrl.pc_stall   = 1'b1;
               w_ctrl.ifid_flush = 1'b1;
            end else begin
               w_ctrl = CTRL_IDLE;
            end
         end
         ST_TRAP_DRAIN: begin
            w_ctrl.pc_stall   = 1'b1;
            w_ctrl.ifid_stall = 1'b1;
            w_ctrl.idex_flush = 1'b1;
            if (!w_mem_wait) begin
               w_state_nxt = ST_TRAP_REDIRECT;
            end else if (r_cnt == TMO_LAST) begin
               // Hung access: kill it in EX/MEM and redirect anyway.
               w_ctrl.exmem_flush = 1'b1;
               w_tmo_nxt          = 1'b1;
               w_state_nxt        = ST_TRAP_REDIRECT;
            end else begin
               w_ctrl.exmem_stall = 1'b1;
               w_cnt_nxt          = r_cnt + TMO_W'(1);
            end
         end
         ST_TRAP_REDIRECT: begin
            w_ctrl.pc_sel       = PC_SEL_TRAP;
            w_ctrl.trap_valid   = 1'b1;
            w_ctrl.trap_cause   = r_cause;
            w_ctrl.trap_timeout = r_tmo;
            w_ctrl.ifid_flush   = 1'b1;
            w_ctrl.idex_flush   = 1'b1;
            w_cnt_nxt           = '0;
            w_tmo_nxt           = 1'b0;
            w_state_nxt         = ST_RUN;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_tmo_nxt   = 1'b0;
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted, independent of inputs.
   always_comb begin
      if (rst_n) begin
         w_ctrl_out = w_ctrl;
      end else begin
         w_ctrl_out = CTRL_IDLE;
      end
      pc_stall       = w_ctrl_out.pc_stall;
      ifid_stall     = w_ctrl_out.ifid_stall;
      idex_stall     = w_ctrl_out.idex_stall;
      exmem_stall    = w_ctrl_out.exmem_stall;
      ifid_flush     = w_ctrl_out.ifid_flush;
      idex_flush     = w_ctrl_out.idex_flush;
      exmem_flush    = w_ctrl_out.exmem_flush;
      pc_sel         = w_ctrl_out.pc_sel;
      csr_trap_valid = w_ctrl_out.trap_valid;
      csr_trap_cause = w_ctrl_out.trap_cause;
      trap_timeout   = w_ctrl_out.trap_timeout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_cause <= 4'd0;
         r_cnt   <= '0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cause <= w_cause_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// Directed-vector bench for elbeth_pipeline_ctrl: a RUN-state table plus
// hand-written trap, timeout and reset sequences.
module tb_elbeth_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_uses_rs1, id_uses_rs2, id_exc, ex_mem_read;
   logic [3:0] id_src;
   logic       ex_branch_taken, ex_xret, mem_dmem_req, dmem_ready, imem_ready;
   logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic       ifid_flush, idex_flush, exmem_flush;
   logic [1:0] pc_sel;
   logic       csr_trap_valid, trap_timeout;
   logic [3:0] csr_trap_cause;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   elbeth_pipeline_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_except_illegal_instruction(id_exc), .id_except_src(id_src),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_xret(ex_xret),
      .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .pc_sel(pc_sel), .csr_trap_valid(csr_trap_valid),
      .csr_trap_cause(csr_trap_cause), .trap_timeout(trap_timeout)
   );

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mrd, exc;
      logic [3:0] src;
      logic       br, xret, mreq, drdy, irdy;
      logic [3:0] es;   // {pc, ifid, idex, exmem} stall
      logic [2:0] ef;   // {ifid, idex, exmem} flush
      logic [1:0] sel;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mrd, input logic exc, input logic [3:0] src,
                                input logic br, input logic xret, input logic mreq,
                                input logic drdy, input logic irdy,
                                input logic [3:0] es, input logic [2:0] ef,
                                input logic [1:0] sel);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.mrd = mrd;
      v.exc = exc; v.src = src; v.br = br; v.xret = xret; v.mreq = mreq;
      v.drdy = drdy; v.irdy = irdy; v.es = es; v.ef = ef; v.sel = sel;
      return v;
   endfunction

   function automatic logic [14:0] mk_exp(input logic [3:0] es, input logic [2:0] ef,
                                          input logic [1:0] sel, input logic v,
                                          input logic [3:0] cause, input logic tmo);
      return {es, ef, sel, v, cause, tmo};
   endfunction

   function automatic logic [14:0] observed();
      return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
              exmem_flush, pc_sel, csr_trap_valid, csr_trap_cause, trap_timeout};
   endfunction

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] got;
      got = observed();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b (stall4 flush3 sel2 valid cause4 tmo)",
                  name, got, exp);
      end
   endtask

   task automatic idle();
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_exc = 1'b0; id_src = 4'd0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_xret = 1'b0;
      mem_dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; ex_rd_addr = v.rd;
      id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; ex_mem_read = v.mrd;
      id_exc = v.exc; id_src = v.src; ex_branch_taken = v.br; ex_xret = v.xret;
      mem_dmem_req = v.mreq; dmem_ready = v.drdy; imem_ready = v.irdy;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // rs1 rs2 u1 u2 rd mrd exc src br xret mreq drdy irdy | stall flush sel
      vecs[0]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00);
      vecs[1]  = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 3'b010, 2'b00);
      vecs[2]  = mkv(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00);
      vecs[3]  = mkv(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 3'b010, 2'b00);
      vecs[4]  = mkv(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00);
      vecs[5]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 3'b000, 2'b00);
      vecs[6]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b110, 2'b01);
      vecs[7]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b110, 2'b11);
      vecs[8]  = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b110, 2'b01);
      vecs[9]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 3'b100, 2'b00);
      vecs[10] = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 3'b010, 2'b00);
      vecs[11] = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00);
      vecs[12] = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b110, 2'b01);
      vecs[13] = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 3'b000, 2'b00);
      vecs[14] = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00);
      vecs[15] = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00);

      // Reset with busy inputs: everything must be quiet.
      apply(vecs[5]);
      #3;
      check("reset_quiet", mk_exp(4'b0000, 3'b000, 2'b00, 1'b0, 4'd0, 1'b0));
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         apply(vecs[i]);
         #1;
         check($sformatf("vec%0d", i), mk_exp(vecs[i].es, vecs[i].ef, vecs[i].sel, 1'b0, 4'd0, 1'b0));
         step();
      end

      // Load-use produces exactly one bubble, then normal flow.
      apply(vecs[1]);
      #1 check("lu_stall", mk_exp(4'b1100, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
      step();
      idle(); id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
      #1 check("lu_after", mk_exp(4'b0000, 3'b000, 2'b00, 1'b0, 4'd0, 1'b0));
      step();

      // Illegal cause 2, no waits: DRAIN at T+1, REDIRECT at T+2, RUN at T+3.
      idle(); id_exc = 1'b1; id_src = 4'h2;
      #1 check("trap_T", mk_exp(4'b1100, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
      step();
      id_src = 4'h7;
      #1 check("trap_drain", mk_exp(4'b1100, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
      step();
      idle(); ex_branch_taken = 1'b1;
      #1 check("trap_redir", mk_exp(4'b0000, 3'b110, 2'b10, 1'b1, 4'h2, 1'b0));
      step();
      idle();
      #1 check("trap_run", mk_exp(4'b0000, 3'b000, 2'b00, 1'b0, 4'd0, 1'b0));
      step();

      // Hung dmem: forced redirect on the 15th wait cycle.
      idle(); id_exc = 1'b1; id_src = 4'h9;
      #1 check("tmo_T", mk_exp(4'b1100, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
      step();
      idle(); mem_dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int w = 0; w < 15; w++) begin
         #1;
         if (w < 14)
            check($sformatf("tmo_wait%0d", w), mk_exp(4'b1101, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
         else
            check("tmo_force", mk_exp(4'b1100, 3'b011, 2'b00, 1'b0, 4'd0, 1'b0));
         step();
      end
      #1 check("tmo_redir", mk_exp(4'b0000, 3'b110, 2'b10, 1'b1, 4'h9, 1'b1));
      step();
      #1 check("tmo_run", mk_exp(4'b1111, 3'b000, 2'b00, 1'b0, 4'd0, 1'b0));
      step();

      // Short drain: 3 waits, then completion; timeout flag must be clear.
      idle(); id_exc = 1'b1; id_src = 4'h5;
      step();
      idle(); mem_dmem_req = 1'b1; dmem_ready = 1'b0;
      step(); step(); step();
      dmem_ready = 1'b1;
      #1 check("short_drain", mk_exp(4'b1100, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
      step();
      idle();
      #1 check("short_redir", mk_exp(4'b0000, 3'b110, 2'b10, 1'b1, 4'h5, 1'b0));
      step();

      // Reset asserted during TRAP_DRAIN.
      idle(); id_exc = 1'b1; id_src = 4'h3;
      step();
      idle(); mem_dmem_req = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0;
      #1 check("rst_drain", mk_exp(4'b1101, 3'b010, 2'b00, 1'b0, 4'd0, 1'b0));
      rst_n = 1'b0;
      #1 check("rst_quiet", mk_exp(4'b0000, 3'b000, 2'b00, 1'b0, 4'd0, 1'b0));
      step();
      idle();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("rst_after%0d", k), mk_exp(4'b0000, 3'b000, 2'b00, 1'b0, 4'd0, 1'b0));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
